// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: byte delivery bundle from the UART receiver to its consumer.
//
// Signals
//   data        last good byte, held until the next good frame
//   data_valid  one-cycle pulse: data has just been updated
//   frame_err   one-cycle pulse: the stop bit of a frame sampled low
//
// Handshake: there is no ready. Each strobe is a single-cycle, registered
// pulse and the consumer must take it on that cycle; data_valid and
// frame_err are never high together, and data stays stable between pulses.
//
// Modports: master drives the bundle (the receiver), slave observes it
// (FIFO, command parser or bench monitor).
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;

  modport master (output data, output data_valid, output frame_err);
  modport slave  (input  data, input  data_valid, input  frame_err);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller on a single system clock.
//
// Synchronises the asynchronous rx pin, schedules mid-bit sampling from a
// per-bit clock divider, sequences start/data/stop reception and delivers
// each byte (or a framing error) as a one-cycle strobe on rx_out.
//
// Ports
//   clk     system clock, rising edge
//   rst     synchronous active-high reset, overrides everything
//   rx      asynchronous serial input, idle high, LSB first, 1 stop bit
//   rx_out  master side of uart_rx_ctrl_if (data, data_valid, frame_err)
//   busy    high whenever the receiver is not idle
//   state   one-hot debug state: IDLE 0001, START 0010, READING 0100, STOP 1000
module uart_rx_ctrl #(
  parameter int BAUD_DIV  = 434,
  parameter int DATA_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  uart_rx_ctrl_if.master        rx_out,
  output logic                  busy,
  output logic [3:0]            state
);

  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV);
  localparam int BW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  localparam logic [3:0] S_IDLE    = 4'b0001;
  localparam logic [3:0] S_START   = 4'b0010;
  localparam logic [3:0] S_READING = 4'b0100;
  localparam logic [3:0] S_STOP    = 4'b1000;

  logic                 rx_m;
  logic                 rx_s;
  logic [3:0]           state_q;
  logic [3:0]           state_d;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] data_q;
  logic                 data_valid_q;
  logic                 frame_err_q;
  logic                 armed;

  // Decoded per-cycle events
  logic half_tick;
  logic bit_tick;
  logic shift_en;
  logic stop_ok;
  logic stop_bad;

  // Two-flop synchroniser; resets to the idle (high) line level so a
  // reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; any non one-hot encoding falls back to idle.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:    state_d = (armed && !rx_s) ? S_START : S_IDLE;
      S_START: begin
        if (half_tick) begin
          // Start bit gone by mid-bit: a glitch, drop it silently.
          state_d = rx_s ? S_IDLE : S_READING;
        end else begin
          state_d = S_START;
        end
      end
      S_READING: state_d = (bit_tick && (bit_cnt == BIT_LAST)) ? S_STOP : S_READING;
      S_STOP:    state_d = bit_tick ? S_IDLE : S_STOP;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / event decode
  always_comb begin
    busy      = (state_q != S_IDLE);
    half_tick = (cnt == CNT_HALF);
    bit_tick  = (cnt == CNT_LAST);
    shift_en  = (state_q == S_READING) && bit_tick;
    stop_ok   = (state_q == S_STOP) && bit_tick && rx_s;
    stop_bad  = (state_q == S_STOP) && bit_tick && !rx_s;
  end

  // Datapath: counters, shift register, delivered byte and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      armed        <= 1'b1;
    end else begin
      data_valid_q <= stop_ok;
      frame_err_q  <= stop_bad;

      // Restart the bit timer on every state entry and after each data
      // sample, so every data sample sits one full bit after the previous.
      if ((state_d != state_q) || shift_en || !busy) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (state_q != S_READING) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      // LSB arrives first, so shifting right leaves it at bit 0 after the
      // last data sample.
      if (shift_en) begin
        shift <= {rx_s, shift[DATA_BITS-1:1]};
      end

      if (stop_ok) begin
        data_q <= shift;
      end

      // After a framing error the line may sit low (break); wait for it to
      // go high again before accepting another start bit.
      if (stop_bad) begin
        armed <= 1'b0;
      end else if (rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign rx_out.data       = data_q;
  assign rx_out.data_valid = data_valid_q;
  assign rx_out.frame_err  = frame_err_q;
  assign state             = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a fast instance (BAUD_DIV=16, 8 bits) for the
// directed and random frames, and a slow instance (BAUD_DIV=434, 7 bits)
// fed with a stretched bit period.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int F_DIV  = 16;
  localparam int F_BITS = 8;
  localparam int S_DIV  = 434;
  localparam int S_BITS = 7;
  localparam int EW     = 41;  // {is_valid, data[7:0], cycle[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rx_f;
  logic rx_sl;
  logic busy_f, busy_s;
  logic [3:0] state_f, state_s;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_ctrl_if #(.DATA_BITS(F_BITS)) if_f ();
  uart_rx_ctrl_if #(.DATA_BITS(S_BITS)) if_s ();

  uart_rx_ctrl #(.BAUD_DIV(F_DIV), .DATA_BITS(F_BITS)) u_fast (
    .clk(clk), .rst(rst), .rx(rx_f), .rx_out(if_f), .busy(busy_f), .state(state_f)
  );

  uart_rx_ctrl #(.BAUD_DIV(S_DIV), .DATA_BITS(S_BITS)) u_slow (
    .clk(clk), .rst(rst), .rx(rx_sl), .rx_out(if_s), .busy(busy_s), .state(state_s)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_f[$];
  logic [EW-1:0] exp_s[$];
  logic [7:0]    last_f = 8'h00;
  logic [7:0]    last_s = 8'h00;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int which, input logic v, input logic fe, input logic [7:0] d);
    logic [EW-1:0] e;
    string nm;
    nm = (which != 0) ? "slow" : "fast";
    if (v || fe) begin
      chk({nm, " strobes exclusive"}, 64'(v & fe), 64'd0);
      if (((which != 0) ? exp_s.size() : exp_f.size()) == 0) begin
        chk({nm, " unexpected strobe"}, 64'({v, fe}), 64'd0);
      end else begin
        e = (which != 0) ? exp_s.pop_front() : exp_f.pop_front();
        chk({nm, " strobe kind"}, 64'({v, fe}), e[40] ? 64'd2 : 64'd1);
        chk({nm, " data"}, 64'(d), 64'(e[39:32]));
        chk({nm, " strobe cycle"}, 64'(cyc), 64'(e[31:0]));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if_f.data_valid, if_f.frame_err, if_f.data);
    mon(1, if_s.data_valid, if_s.frame_err, {1'b0, if_s.data});
  end

  // State-change trace of the fast instance.
  logic [3:0] prev_f = 4'b0001;
  logic [3:0] tr_st[$];
  int         tr_cyc[$];

  always @(negedge clk) begin
    if (state_f !== prev_f) begin
      tr_st.push_back(state_f);
      tr_cyc.push_back(cyc);
      prev_f = state_f;
      chk("fast busy vs state", 64'(busy_f), 64'(state_f != 4'b0001));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which != 0) rx_sl = v;
    else rx_f = v;
  endtask

  // Sends start + data + stop, each lasting blen cycles. A good stop bit
  // leaves the line high; a bad (low) stop bit leaves it low for the caller.
  // The expected strobe: pin edge reaches rx_s two cycles later (t0), the
  // stop is sampled at t0+HALF+(bits+1)*DIV, the strobe appears a cycle after.
  task automatic send(input int which, input logic [7:0] b, input logic stop, input int blen);
    int div, nb, t0;
    logic [7:0] bm;
    logic [EW-1:0] e;
    div = (which != 0) ? S_DIV : F_DIV;
    nb  = (which != 0) ? S_BITS : F_BITS;
    bm  = (which != 0) ? (b & 8'h7F) : b;
    t0  = cyc + 2;
    if (stop) begin
      if (which != 0) last_s = bm;
      else last_f = bm;
    end
    e = {stop, ((which != 0) ? last_s : last_f), 32'(t0 + div / 2 + (nb + 1) * div + 1)};
    if (which != 0) exp_s.push_back(e);
    else exp_f.push_back(e);
    set_rx(which, 1'b0);
    tick(blen);
    for (int k = 0; k < nb; k++) begin
      set_rx(which, b[k]);
      tick(blen);
    end
    set_rx(which, stop);
    tick(blen);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int n0;
    logic [7:0] rb;
    logic [3:0] exp_st[4];
    int         exp_off[4];

    rst   = 1'b1;
    rx_f  = 1'b1;
    rx_sl = 1'b1;
    tick(3);
    chk("reset state", 64'(state_f), 64'h1);
    chk("reset busy", 64'(busy_f), 64'd0);
    chk("reset data", 64'(if_f.data), 64'd0);
    chk("reset data_valid", 64'(if_f.data_valid), 64'd0);
    chk("reset frame_err", 64'(if_f.frame_err), 64'd0);
    chk("reset slow state", 64'(state_s), 64'h1);
    rst = 1'b0;
    tick(5);

    // 0xA5 with state sequence and timing
    tr_st.delete();
    tr_cyc.delete();
    t0 = cyc + 2;
    send(0, 8'hA5, 1'b1, F_DIV);
    tick(5);
    exp_st[0] = 4'b0010; exp_off[0] = 1;
    exp_st[1] = 4'b0100; exp_off[1] = 9;
    exp_st[2] = 4'b1000; exp_off[2] = 137;
    exp_st[3] = 4'b0001; exp_off[3] = 153;
    chk("a5 trace length", 64'(tr_st.size()), 64'd4);
    if (tr_st.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("a5 trace state", 64'(tr_st[k]), 64'(exp_st[k]));
        chk("a5 trace cycle", 64'(tr_cyc[k]), 64'(t0 + exp_off[k]));
      end
    end

    // Back-to-back 0x00 then 0xFF, no idle between frames
    send(0, 8'h00, 1'b1, F_DIV);
    send(0, 8'hFF, 1'b1, F_DIV);
    tick(20);

    // 4-cycle glitch on the idle line
    tr_st.delete();
    tr_cyc.delete();
    t0 = cyc + 2;
    set_rx(0, 1'b0);
    tick(4);
    set_rx(0, 1'b1);
    tick(20);
    chk("glitch trace length", 64'(tr_st.size()), 64'd2);
    if (tr_st.size() == 2) begin
      chk("glitch start state", 64'(tr_st[0]), 64'h2);
      chk("glitch start cycle", 64'(tr_cyc[0]), 64'(t0 + 1));
      chk("glitch idle state", 64'(tr_st[1]), 64'h1);
      chk("glitch idle cycle", 64'(tr_cyc[1]), 64'(t0 + 9));
    end
    chk("glitch data kept", 64'(if_f.data), 64'(last_f));

    // Framing error, then the line held low: no re-trigger
    send(0, 8'h3C, 1'b0, F_DIV);
    tr_st.delete();
    tr_cyc.delete();
    tick(40);
    chk("break no retrigger", 64'(tr_st.size()), 64'd0);
    chk("break state idle", 64'(state_f), 64'h1);
    chk("ferr data kept", 64'(if_f.data), 64'(last_f));
    set_rx(0, 1'b1);
    tick(3);
    send(0, 8'h12, 1'b1, F_DIV);
    tick(5);

    // Reset in the middle of data bit 3
    rb = 8'($urandom_range(0, 255));
    set_rx(0, 1'b0);
    tick(F_DIV);
    for (int k = 0; k < 3; k++) begin
      set_rx(0, rb[k]);
      tick(F_DIV);
    end
    set_rx(0, rb[3]);
    tick(F_DIV / 2);
    chk("pre-reset reading", 64'(state_f), 64'h4);
    rst = 1'b1;
    tick(1);
    chk("mid reset state", 64'(state_f), 64'h1);
    chk("mid reset busy", 64'(busy_f), 64'd0);
    chk("mid reset data", 64'(if_f.data), 64'd0);
    chk("mid reset data_valid", 64'(if_f.data_valid), 64'd0);
    chk("mid reset frame_err", 64'(if_f.frame_err), 64'd0);
    rst    = 1'b0;
    last_f = 8'h00;
    last_s = 8'h00;
    set_rx(0, 1'b1);
    tick(30);
    send(0, 8'h81, 1'b1, F_DIV);
    tick(5);

    // Random frames, occasional framing errors with a low hold afterwards
    for (int n = 0; n < 30; n++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        send(0, rb, 1'b0, F_DIV);
        tick($urandom_range(0, 12));
        set_rx(0, 1'b1);
        tick($urandom_range(2, 8));
      end else begin
        send(0, rb, 1'b1, F_DIV);
        tick($urandom_range(0, 6));
      end
    end

    // Slow instance: 7-bit 0x55 with the bit period stretched by 3%
    send(1, 8'h55, 1'b1, 447);
    set_rx(1, 1'b1);
    tick(10);

    n0 = 0;
    while ((exp_f.size() + exp_s.size()) != 0 && n0 < 6000) begin
      tick(1);
      n0++;
    end
    chk("scoreboard drained", 64'(exp_f.size() + exp_s.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
